dealigner: RTL and testbench

- Decompression-side counterpart of the compression-side output aligner.
- Accepts the packed 256-bit stream, where variable-length compressed chunks are concatenated byte-contiguously with no per-chunk padding.
- Re-extracts consumer-requested byte counts, LSB-aligned, so the decoder sees each chunk starting at bit 0.
- Sits between the input AXI-stream FIFO and the decompression engine.

---
 rtl/dealign_pkg.sv | 53 +++++
 rtl/dealigner_funnel.sv | 30 +++
 rtl/dealigner.sv | 124 ++++++++++++
 tb/tb_dealigner.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/dealign_pkg.sv
// dealign_pkg: shared widths, FSM state type and byte-count helpers for the
// stream dealigner and any other byte realigner built on the funnel shifter.
package dealign_pkg;

  localparam int DATA_IN_WIDTH  = 256;                    // packed input word (bits)
  localparam int DATA_OUT_WIDTH = 272;                    // extraction window (bits)
  localparam int LEN_WIDTH      = 8;                      // request/response length field
  localparam int BUF_BYTES      = 64;                     // residual buffer capacity
  localparam int MAX_REQ        = 34;                     // largest legal request (bytes)
  localparam int IN_BYTES       = DATA_IN_WIDTH / 8;
  localparam int OUT_BYTES      = DATA_OUT_WIDTH / 8;
  localparam int BUF_BITS       = BUF_BYTES * 8;
  localparam int FILL_W         = $clog2(BUF_BYTES + 1);  // holds 0..BUF_BYTES

  typedef enum logic {
    STREAM = 1'b0,
    DRAIN  = 1'b1
  } state_t;

  // Number of consecutive set bits in tkeep starting at bit 0.
  function automatic logic [FILL_W-1:0] leading_ones(input logic [IN_BYTES-1:0] tkeep);
    logic              run;
    logic [FILL_W-1:0] cnt;
    run = 1'b1;
    cnt = '0;
    for (int i = 0; i < IN_BYTES; i++) begin
      run = run & tkeep[i];
      cnt = cnt + {{(FILL_W-1){1'b0}}, run};
    end
    return cnt;
  endfunction

  // Bit mask covering the lowest nbytes bytes of the residual buffer.
  function automatic logic [BUF_BITS-1:0] byte_mask(input logic [FILL_W-1:0] nbytes);
    logic [BUF_BITS-1:0] m;
    m = '0;
    for (int i = 0; i < BUF_BYTES; i++) begin
      if (i < int'(nbytes)) m[i*8 +: 8] = 8'hFF;
    end
    return m;
  endfunction

  // Bit mask covering the lowest nbytes bytes of the extraction window.
  function automatic logic [DATA_OUT_WIDTH-1:0] window_mask(input logic [FILL_W-1:0] nbytes);
    logic [DATA_OUT_WIDTH-1:0] m;
    m = '0;
    for (int i = 0; i < OUT_BYTES; i++) begin
      if (i < int'(nbytes)) m[i*8 +: 8] = 8'hFF;
    end
    return m;
  endfunction

endpackage

// File: rtl/dealigner_funnel.sv
// byte_funnel_shifter: combinational byte-granular realigner.
//   buf_cur   - current residual buffer, byte 0 at bits [7:0]
//   pop       - bytes removed from the bottom this cycle
//   keep      - bytes that survive the pop (fill - pop)
//   ins_data  - incoming word, byte 0 at bits [7:0]
//   ins_bytes - how many low bytes of ins_data are appended
//   buf_next  - shifted buffer with the new bytes appended at byte 'keep'
// Everything above keep + ins_bytes is forced to zero, so the buffer register
// itself needs no reset.
module byte_funnel_shifter
  import dealign_pkg::*;
(
  input  logic [BUF_BITS-1:0]      buf_cur,
  input  logic [FILL_W-1:0]        pop,
  input  logic [FILL_W-1:0]        keep,
  input  logic [DATA_IN_WIDTH-1:0] ins_data,
  input  logic [FILL_W-1:0]        ins_bytes,
  output logic [BUF_BITS-1:0]      buf_next
);

  logic [BUF_BITS-1:0] shifted;
  logic [BUF_BITS-1:0] ins_wide;

  always_comb begin
    shifted  = (buf_cur >> {pop, 3'b000}) & byte_mask(keep);
    ins_wide = {{(BUF_BITS-DATA_IN_WIDTH){1'b0}}, ins_data} & byte_mask(ins_bytes);
    buf_next = shifted | (ins_wide << {keep, 3'b000});
  end

endmodule

// File: rtl/dealigner.sv
// dealigner: re-extracts consumer-sized byte chunks from a byte-contiguous
// packed stream, delivering each chunk LSB-aligned.
//   clk, reset          - clock, synchronous active-high reset
//   in_valid/in_ready   - packed input word handshake
//   in_data/in_tkeep    - packed bytes and LSB-contiguous byte enables
//   in_tlast            - last word of the stream; switches to drain mode
//   req_valid/req_ready - extraction request handshake, req_len bytes (1..34)
//   out_valid           - one-cycle response pulse (no backpressure)
//   out_data/out_len    - extracted bytes (zero above out_len) and their count
//   out_last            - response carries the final byte of the stream
//   err                 - sticky protocol error (gapped tkeep, illegal length)
module dealigner
  import dealign_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_IN_WIDTH-1:0]  in_data,
  input  logic [IN_BYTES-1:0]       in_tkeep,
  input  logic                      in_tlast,
  input  logic                      req_valid,
  input  logic [LEN_WIDTH-1:0]      req_len,
  output logic                      req_ready,
  output logic                      out_valid,
  output logic [DATA_OUT_WIDTH-1:0] out_data,
  output logic [LEN_WIDTH-1:0]      out_len,
  output logic                      out_last,
  output logic                      err
);

  state_t                    state_q;
  logic [FILL_W-1:0]         fill_q;
  logic [FILL_W-1:0]         fill_next;
  logic [FILL_W-1:0]         keep_bytes;
  logic [FILL_W-1:0]         pop;
  logic [FILL_W-1:0]         n_lead;
  logic [FILL_W-1:0]         n_push;
  logic [BUF_BITS-1:0]       buf_q;
  logic [BUF_BITS-1:0]       buf_next;
  logic [DATA_OUT_WIDTH-1:0] pop_window;
  logic                      req_legal;
  logic                      push;
  logic                      req_fire;
  logic                      pop_fire;
  logic                      last_resp;
  logic                      tkeep_gap;

  always_comb begin
    req_legal = (req_len != '0) && (req_len <= LEN_WIDTH'(MAX_REQ));

    // Room for a full word is judged on the current fill only, so the
    // ready path never depends on the same-cycle pop.
    in_ready  = !reset && (state_q == STREAM) &&
                (fill_q <= FILL_W'(BUF_BYTES - IN_BYTES));

    // Illegal lengths are always swallowed so a bad request cannot stall.
    req_ready = !reset && ((state_q == DRAIN) || !req_legal ||
                           (LEN_WIDTH'(fill_q) >= req_len));

    push     = in_valid && in_ready;
    req_fire = req_valid && req_ready;
    pop_fire = req_fire && req_legal;

    n_lead    = leading_ones(in_tkeep);
    n_push    = push ? n_lead : '0;
    // Any enable left after stripping the leading run means a gap.
    tkeep_gap = |(in_tkeep >> n_lead);

    // Only DRAIN can see req_len > fill; it then delivers what is left.
    pop = '0;
    if (pop_fire) begin
      pop = (LEN_WIDTH'(fill_q) < req_len) ? fill_q : FILL_W'(req_len);
    end

    keep_bytes = fill_q - pop;
    fill_next  = keep_bytes + n_push;
    last_resp  = pop_fire && (state_q == DRAIN) && (pop == fill_q);

    pop_window = buf_q[DATA_OUT_WIDTH-1:0] & window_mask(pop);
  end

  byte_funnel_shifter u_funnel (
    .buf_cur   (buf_q),
    .pop       (pop),
    .keep      (keep_bytes),
    .ins_data  (in_data),
    .ins_bytes (n_push),
    .buf_next  (buf_next)
  );

  // Stage boundary: control state and registered response.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= STREAM;
      fill_q    <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_len   <= '0;
      out_data  <= '0;
      err       <= 1'b0;
    end else begin
      out_valid <= pop_fire;
      out_last  <= last_resp;
      if (pop_fire) begin
        out_data <= pop_window;
        out_len  <= LEN_WIDTH'(pop);
      end
      err    <= err | (push && tkeep_gap) | (req_fire && !req_legal);
      fill_q <= fill_next;
      if (last_resp) begin
        state_q <= STREAM;
      end else if (push && in_tlast) begin
        state_q <= DRAIN;
      end
    end
  end

  // Stage boundary: residual buffer; bytes above fill are masked, no reset needed.
  always_ff @(posedge clk) begin
    buf_q <= buf_next;
  end

endmodule

// File: tb/tb_dealigner.sv
module tb_dealigner;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [255:0] in_data;
  logic [31:0]  in_tkeep;
  logic         in_tlast;
  logic         req_valid;
  logic [7:0]   req_len;
  logic         req_ready;
  logic         out_valid;
  logic [271:0] out_data;
  logic [7:0]   out_len;
  logic         out_last;
  logic         err;

  always #5 clk = ~clk;

  dealigner dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_tkeep  (in_tkeep),
    .in_tlast  (in_tlast),
    .req_valid (req_valid),
    .req_len   (req_len),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_len   (out_len),
    .out_last  (out_last),
    .err       (err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [271:0] obs, input logic [271:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: the buffer is just a queue of bytes in stream order.
  logic [7:0]   mq[$];
  logic         m_drain;
  logic         m_err;
  logic         e_valid;
  logic         e_last;
  logic [7:0]   e_len;
  logic [271:0] e_data;
  logic         have_exp = 1'b0;

  task automatic check_outputs();
    if (have_exp) begin
      chk("out_valid", 272'(out_valid), 272'(e_valid));
      chk("out_last",  272'(out_last),  272'(e_last));
      chk("out_len",   272'(out_len),   272'(e_len));
      chk("out_data",  out_data,        e_data);
      chk("err",       272'(err),       272'(m_err));
    end
  endtask

  // One clock cycle: check last edge's outputs, drive, check readies, advance model.
  task automatic step(input logic r, input logic iv, input logic [255:0] d,
                      input logic [31:0] k, input logic tl,
                      input logic rv, input logic [7:0] rl);
    int sz;
    int p;
    int n;
    int ones;
    bit legal;
    bit x_in_rdy;
    bit x_req_rdy;
    @(negedge clk);
    check_outputs();
    reset     = r;
    in_valid  = iv;
    in_data   = d;
    in_tkeep  = k;
    in_tlast  = tl;
    req_valid = rv;
    req_len   = rl;
    #1;
    if (r) begin
      chk("in_ready_rst",  272'(in_ready),  272'(0));
      chk("req_ready_rst", 272'(req_ready), 272'(0));
      mq.delete();
      m_drain  = 1'b0;
      m_err    = 1'b0;
      e_valid  = 1'b0;
      e_last   = 1'b0;
      e_len    = '0;
      e_data   = '0;
      have_exp = 1'b1;
    end else begin
      sz        = mq.size();
      legal     = (rl >= 1) && (rl <= 34);
      x_in_rdy  = !m_drain && (sz <= 32);
      x_req_rdy = m_drain || !legal || (sz >= int'(rl));
      chk("in_ready",  272'(in_ready),  272'(x_in_rdy));
      chk("req_ready", 272'(req_ready), 272'(x_req_rdy));
      e_valid = 1'b0;
      e_last  = 1'b0;
      if (rv && x_req_rdy) begin
        if (!legal) begin
          m_err = 1'b1;
        end else begin
          p      = (int'(rl) < sz) ? int'(rl) : sz;
          e_data = '0;
          for (int i = 0; i < p; i++) e_data[i*8 +: 8] = mq.pop_front();
          e_len   = 8'(p);
          e_valid = 1'b1;
          if (m_drain && p == sz) begin
            e_last  = 1'b1;
            m_drain = 1'b0;
          end
        end
      end
      if (iv && x_in_rdy) begin
        n    = 0;
        ones = 0;
        while (n < 32 && k[n]) n++;
        for (int i = 0; i < 32; i++) ones += int'(k[i]);
        if (ones != n) m_err = 1'b1;
        for (int i = 0; i < n; i++) mq.push_back(d[i*8 +: 8]);
        if (tl) m_drain = 1'b1;
      end
    end
  endtask

  function automatic logic [255:0] seq_word(input int start);
    logic [255:0] w;
    for (int i = 0; i < 32; i++) w[i*8 +: 8] = 8'(start + i);
    return w;
  endfunction

  task automatic push_w(input logic [255:0] d, input logic [31:0] k, input logic tl);
    step(1'b0, 1'b1, d, k, tl, 1'b0, 8'd0);
  endtask

  task automatic req(input logic [7:0] l);
    step(1'b0, 1'b0, '0, '0, 1'b0, 1'b1, l);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 8'd0);
  endtask

  initial begin
    logic [255:0] d;
    logic [31:0]  k;
    logic [7:0]   rl;
    int           n;

    reset = 1'b1; in_valid = 1'b0; in_data = '0; in_tkeep = '0;
    in_tlast = 1'b0; req_valid = 1'b0; req_len = '0;

    step(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, 8'd0);
    step(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, 8'd0);
    idle();

    // Two full words then 6x10 + 4 bytes; afterwards nothing is left.
    push_w(seq_word(0),  32'hFFFF_FFFF, 1'b0);
    push_w(seq_word(32), 32'hFFFF_FFFF, 1'b0);
    for (int i = 0; i < 6; i++) req(8'd10);
    req(8'd4);
    req(8'd1);
    idle();

    // fill=5, request 8 waits until the next word lands.
    push_w(seq_word(0), 32'h0000_001F, 1'b0);
    req(8'd8);
    req(8'd8);
    step(1'b0, 1'b1, seq_word(5), 32'hFFFF_FFFF, 1'b0, 1'b1, 8'd8);
    req(8'd8);
    idle();

    // fill 29 -> 30, then push 32 while popping 20 -> 42.
    push_w(seq_word(200), 32'h0000_0001, 1'b0);
    step(1'b0, 1'b1, seq_word(64), 32'hFFFF_FFFF, 1'b0, 1'b1, 8'd20);
    req(8'd42);
    req(8'd34);
    req(8'd8);
    idle();

    // Short final word with tlast, then an oversized drain request.
    push_w(seq_word(90), 32'h0000_0007, 1'b0);
    push_w(seq_word(93), 32'h0000_00FF, 1'b1);
    step(1'b0, 1'b1, seq_word(120), 32'hFFFF_FFFF, 1'b0, 1'b1, 8'd20);
    push_w(seq_word(150), 32'hFFFF_FFFF, 1'b0);

    // Illegal lengths, then legal requests still return the right bytes.
    req(8'd0);
    req(8'd40);
    req(8'd20);
    req(8'd12);
    idle();

    // Reset with 40 bytes buffered and a request presented.
    push_w(seq_word(10), 32'hFFFF_FFFF, 1'b0);
    push_w(seq_word(42), 32'h0000_00FF, 1'b0);
    step(1'b1, 1'b0, '0, '0, 1'b0, 1'b1, 8'd10);
    idle();
    req(8'd1);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      for (int w = 0; w < 8; w++) d[w*32 +: 32] = $urandom;
      n = $urandom_range(0, 32);
      k = (n == 32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
      if ($urandom_range(0, 63) == 0) k = $urandom;
      rl = ($urandom_range(0, 63) == 0) ? 8'($urandom_range(0, 255))
                                        : 8'($urandom_range(1, 34));
      step(1'($urandom_range(0, 299) == 0), 1'($urandom_range(0, 1)), d, k,
           1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 9) < 6), rl);
    end

    @(negedge clk);
    check_outputs();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
